// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_pkg
// Purpose  : Shared constants and helpers for the floating-point front end.
//            - one-hot class bit indices used on out_class
//            - binary32 default field widths and bias
//            - exponent all-ones helper
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package fp_pkg;

  // Bit positions inside the one-hot class vector {snan,qnan,inf,norm,sub,zero}
  localparam int CLS_ZERO = 0;
  localparam int CLS_SUB  = 1;
  localparam int CLS_NORM = 2;
  localparam int CLS_INF  = 3;
  localparam int CLS_QNAN = 4;
  localparam int CLS_SNAN = 5;
  localparam int CLS_W    = 6;

  // binary32 defaults
  localparam int EXP_W_B32 = 8;
  localparam int MAN_W_B32 = 23;
  localparam int BIAS_B32  = 127;

  // Value of an all-ones exponent field of the given width
  function automatic int exp_ones(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

endpackage : fp_pkg
`default_nettype wire

// File: rtl/fp_lzc.sv
`default_nettype none
// ============================================================================
// Module   : fp_lzc
// Purpose  : Purely combinational leading-zero counter. Returns W when the
//            input is all zeros. Shared by the unpack stage and the
//            post-product normaliser.
// Ports    : data_i  [W-1:0]          input word
//            lzc_o   [clog2(W+1)-1:0] number of leading zeros (0..W)
// Revision : 1.0  initial release
// ============================================================================
module fp_lzc #(
  parameter int W  = 23,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  data_i,
  output logic [CW-1:0] lzc_o
);

  // Scan upward; the last set bit seen is the most significant one, so it
  // determines the count.
  always_comb begin
    lzc_o = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (data_i[i]) begin
        lzc_o = CW'(W - 1 - i);
      end
    end
  end

endmodule : fp_lzc
`default_nettype wire

// File: rtl/fp_unpack_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_unpack_pipe
// Purpose  : Two-stage pipelined IEEE-754 operand unpacker. Splits sign,
//            exponent and mantissa, classifies the operand, restores the
//            hidden bit, unbiases the exponent and normalises subnormals.
//            S1 registers split fields, class and mantissa lzc; S2 (output
//            register) forms the exponent and significand.
// Ports    : clk, rst                 clock, synchronous active-high reset
//            in_valid/in_ready        input stream handshake
//            in_number [1+EXP_W+MAN_W-1:0]  {sign, exponent, mantissa}
//            out_valid/out_ready      output stream handshake
//            out_sign                 input sign
//            out_exp   [EXP_W+1:0]    signed unbiased normalised exponent
//            out_sig   [MAN_W:0]      normalised significand, MSB = integer
//            out_class [5:0]          one-hot {snan,qnan,inf,norm,sub,zero}
// Revision : 1.0  initial release
// ============================================================================
module fp_unpack_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = EXP_W_B32,
  parameter int MAN_W = MAN_W_B32,
  parameter int BIAS  = BIAS_B32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     in_number,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sign,
  output logic [EXP_W+1:0]         out_exp,
  output logic [MAN_W:0]           out_sig,
  output logic [CLS_W-1:0]         out_class
);

  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(MAN_W + 1);

  localparam logic [EXP_W-1:0] C_EXP_ONES    = EXP_W'(exp_ones(EXP_W));
  localparam logic [EW-1:0]    C_BIAS        = EW'(BIAS);
  localparam logic [EW-1:0]    C_SPECIAL_EXP = EW'(exp_ones(EXP_W) - BIAS);

  if (BIAS != (2 ** (EXP_W - 1)) - 1) begin : g_bias_check
    $error("fp_unpack_pipe: BIAS must equal 2^(EXP_W-1)-1");
  end

  // --------------------------------------------------------------------------
  // Field split and classification (feeds S1)
  // --------------------------------------------------------------------------
  logic               w_sign;
  logic [EXP_W-1:0]   w_exp;
  logic [MAN_W-1:0]   w_man;
  logic               w_exp_zero;
  logic               w_exp_ones;
  logic               w_man_zero;
  logic [CLS_W-1:0]   w_cls;
  logic [CW-1:0]      w_lzc;

  assign w_sign     = in_number[EXP_W+MAN_W];
  assign w_exp      = in_number[MAN_W +: EXP_W];
  assign w_man      = in_number[MAN_W-1:0];
  assign w_exp_zero = (w_exp == '0);
  assign w_exp_ones = (w_exp == C_EXP_ONES);
  assign w_man_zero = (w_man == '0);

  always_comb begin
    w_cls = '0;
    if (w_exp_zero) begin
      if (w_man_zero) w_cls[CLS_ZERO] = 1'b1;
      else            w_cls[CLS_SUB]  = 1'b1;
    end else if (w_exp_ones) begin
      // The mantissa MSB is the quiet bit
      if (w_man_zero)             w_cls[CLS_INF]  = 1'b1;
      else if (w_man[MAN_W-1])    w_cls[CLS_QNAN] = 1'b1;
      else                        w_cls[CLS_SNAN] = 1'b1;
    end else begin
      w_cls[CLS_NORM] = 1'b1;
    end
  end

  fp_lzc #(.W(MAN_W)) u_lzc (
    .data_i (w_man),
    .lzc_o  (w_lzc)
  );

  // --------------------------------------------------------------------------
  // Flow control: S2 loads whenever its slot is free or being drained; S1
  // can take a word whenever it is empty or emptying into S2.
  // --------------------------------------------------------------------------
  logic w_s2_load;
  logic out_valid_q;
  logic s1_valid_q;

  assign w_s2_load = !out_valid_q | out_ready;
  assign in_ready  = !s1_valid_q | w_s2_load;

  // --------------------------------------------------------------------------
  // S1 register
  // --------------------------------------------------------------------------
  logic               s1_sign_q;
  logic [EXP_W-1:0]   s1_exp_q;
  logic [MAN_W-1:0]   s1_man_q;
  logic [CLS_W-1:0]   s1_cls_q;
  logic [CW-1:0]      s1_lzc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_man_q   <= '0;
      s1_cls_q   <= '0;
      s1_lzc_q   <= '0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sign_q <= w_sign;
        s1_exp_q  <= w_exp;
        s1_man_q  <= w_man;
        s1_cls_q  <= w_cls;
        s1_lzc_q  <= w_lzc;
      end
    end
  end

  // --------------------------------------------------------------------------
  // S2 arithmetic
  // --------------------------------------------------------------------------
  logic [EW-1:0]    out_exp_d;
  logic [MAN_W:0]   out_sig_d;

  always_comb begin
    out_exp_d = '0;
    out_sig_d = '0;
    if (s1_cls_q[CLS_NORM]) begin
      out_exp_d = {2'b00, s1_exp_q} - C_BIAS;
      out_sig_d = {1'b1, s1_man_q};
    end else if (s1_cls_q[CLS_SUB]) begin
      // Subnormal exponent is 1-BIAS; shifting the integer bit into place
      // costs lzc+1 positions, hence -BIAS-lzc.
      out_exp_d = -C_BIAS - EW'(s1_lzc_q);
      out_sig_d = {s1_man_q, 1'b0} << s1_lzc_q;
    end else if (s1_cls_q[CLS_INF] | s1_cls_q[CLS_QNAN] | s1_cls_q[CLS_SNAN]) begin
      // Infinity has a zero mantissa, so the same form keeps NaN payloads
      out_exp_d = C_SPECIAL_EXP;
      out_sig_d = {1'b1, s1_man_q};
    end
  end

  // --------------------------------------------------------------------------
  // S2 (output) register
  // --------------------------------------------------------------------------
  logic               out_sign_q;
  logic [EW-1:0]      out_exp_q;
  logic [MAN_W:0]     out_sig_q;
  logic [CLS_W-1:0]   out_class_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      out_exp_q   <= '0;
      out_sig_q   <= '0;
      out_class_q <= '0;
    end else if (w_s2_load) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_sign_q  <= s1_sign_q;
        out_exp_q   <= out_exp_d;
        out_sig_q   <= out_sig_d;
        out_class_q <= s1_cls_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sign  = out_sign_q;
  assign out_exp   = out_exp_q;
  assign out_sig   = out_sig_q;
  assign out_class = out_class_q;

endmodule : fp_unpack_pipe
`default_nettype wire

// File: tb/tb_fp_unpack_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_unpack_pipe
// Purpose  : Self-checking bench for fp_unpack_pipe. Two instances run side
//            by side: binary32 (lane 0) and binary16 layout (lane 1).
//            Outputs are compared against a value-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fp_unpack_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Lane 0: EXP_W=8, MAN_W=23
  logic        iv0, ir0, ov0, or0, os0;
  logic [31:0] in0;
  logic [9:0]  oe0;
  logic [23:0] sg0;
  logic [5:0]  oc0;
  // Lane 1: EXP_W=5, MAN_W=10
  logic        iv1, ir1, ov1, or1, os1;
  logic [15:0] in1;
  logic [6:0]  oe1;
  logic [10:0] sg1;
  logic [5:0]  oc1;

  fp_unpack_pipe #(.EXP_W(8), .MAN_W(23), .BIAS(127)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .in_number(in0),
    .out_valid(ov0), .out_ready(or0), .out_sign(os0), .out_exp(oe0),
    .out_sig(sg0), .out_class(oc0)
  );

  fp_unpack_pipe #(.EXP_W(5), .MAN_W(10), .BIAS(15)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_number(in1),
    .out_valid(ov1), .out_ready(or1), .out_sign(os1), .out_exp(oe1),
    .out_sig(sg1), .out_class(oc1)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Value-level model: the significand/exponent pair must represent the same
  // number as the packed word, with the integer bit at position mw.
  function automatic void ref_model(input logic [31:0] w, input int ew, input int mw,
                                    output logic s, output int ex,
                                    output logic [31:0] sig, output logic [5:0] cls);
    int bias, emax, e, m, p, shift;
    bias = (1 << (ew - 1)) - 1;
    emax = (1 << ew) - 1;
    e    = int'(w >> mw) & emax;
    m    = int'(w) & ((1 << mw) - 1);
    s    = w[ew + mw];
    if (e == 0 && m == 0) begin
      cls = 6'b000001; ex = 0; sig = 32'd0;
    end else if (e == 0) begin
      p = 0;
      for (int i = 0; i < mw; i++) if (((m >> i) & 1) == 1) p = i;
      shift = mw - p;
      sig   = 32'(m) << shift;
      ex    = 1 - bias - shift;
      cls   = 6'b000010;
    end else if (e == emax) begin
      ex  = emax - bias;
      sig = 32'((1 << mw) | m);
      if (m == 0)                    cls = 6'b001000;
      else if (((m >> (mw - 1)) & 1) == 1) cls = 6'b010000;
      else                           cls = 6'b100000;
    end else begin
      ex  = e - bias;
      sig = 32'((1 << mw) | m);
      cls = 6'b000100;
    end
  endfunction

  // Biased toward zero/all-ones exponents and sparse mantissas
  function automatic logic [31:0] gen_word(input int ew, input int mw);
    int emax, e, m;
    emax = (1 << ew) - 1;
    case ($urandom_range(0, 9))
      0:       e = 0;
      1:       e = emax;
      default: e = int'($urandom_range(1, emax - 1));
    endcase
    case ($urandom_range(0, 5))
      0:       m = 0;
      1:       m = 1 << $urandom_range(0, mw - 1);
      default: m = int'($urandom) & ((1 << mw) - 1);
    endcase
    return (32'($urandom_range(0, 1)) << (ew + mw)) | (32'(e) << mw) | 32'(m);
  endfunction

  logic [31:0] sb0[$];
  logic [31:0] sb1[$];
  int acc0 = 0, acc1 = 0, pop0 = 0, pop1 = 0;
  logic hold0 = 1'b0, hold1 = 1'b0;
  logic st0 = 1'b0, st1 = 1'b0;
  logic [40:0] snap0;
  logic [24:0] snap1;

  // Called between clock edges with new inputs applied; observes the
  // handshakes that the coming rising edge will perform, then advances.
  task automatic tick();
    logic s; int ex; logic [31:0] sig; logic [5:0] cls; logic [31:0] w;
    #1;
    if (rst) begin
      sb0.delete(); sb1.delete();
      st0 = 1'b0; st1 = 1'b0; hold0 = 1'b0; hold1 = 1'b0;
    end else begin
      if (st0) chk("lane0_hold", 64'({os0, oe0, sg0, oc0}), 64'(snap0));
      if (st1) chk("lane1_hold", 64'({os1, oe1, sg1, oc1}), 64'(snap1));
      if (ov0 && or0) begin
        if (sb0.size() == 0) chk("lane0_stale", 64'(ov0), 64'(0));
        else begin
          w = sb0.pop_front();
          ref_model(w, 8, 23, s, ex, sig, cls);
          chk("lane0_out", 64'({os0, oe0, sg0, oc0}), 64'({s, ex[9:0], sig[23:0], cls}));
          pop0++;
        end
      end
      if (ov1 && or1) begin
        if (sb1.size() == 0) chk("lane1_stale", 64'(ov1), 64'(0));
        else begin
          w = sb1.pop_front();
          ref_model(w, 5, 10, s, ex, sig, cls);
          chk("lane1_out", 64'({os1, oe1, sg1, oc1}), 64'({s, ex[6:0], sig[10:0], cls}));
          pop1++;
        end
      end
      st0 = ov0 && !or0; snap0 = {os0, oe0, sg0, oc0};
      st1 = ov1 && !or1; snap1 = {os1, oe1, sg1, oc1};
      hold0 = iv0 && !ir0;
      hold1 = iv1 && !ir1;
      if (iv0 && ir0) begin sb0.push_back(in0); acc0++; end
      if (iv1 && ir1) begin sb1.push_back({16'd0, in1}); acc1++; end
    end
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Directed binary32 vectors with hand-derived results
  logic [31:0] d_w[8]   = '{32'h3F800000, 32'hC0490FDB, 32'h00000001, 32'h00400000,
                            32'h80000000, 32'h7F800000, 32'h7FC00001, 32'h7F800001};
  logic        d_s[8]   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  int          d_ex[8]  = '{0, 1, -149, -127, 0, 128, 128, 128};
  logic [23:0] d_sig[8] = '{24'h800000, 24'hC90FDB, 24'h800000, 24'h800000,
                            24'h000000, 24'h800000, 24'hC00001, 24'h800001};
  logic [5:0]  d_cls[8] = '{6'b000100, 6'b000100, 6'b000010, 6'b000010,
                            6'b000001, 6'b001000, 6'b010000, 6'b100000};

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, p0s, p1s, cyc;
    logic [9:0] dex;
    iv0 = 1'b0; in0 = '0; or0 = 1'b1;
    iv1 = 1'b0; in1 = '0; or1 = 1'b1;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_l0_valid", 64'(ov0), 64'(0));
    chk("rst_l0_ready", 64'(ir0), 64'(1));
    chk("rst_l0_data",  64'({os0, oe0, sg0, oc0}), 64'(0));
    chk("rst_l1_valid", 64'(ov1), 64'(0));
    chk("rst_l1_ready", 64'(ir1), 64'(1));
    chk("rst_l1_data",  64'({os1, oe1, sg1, oc1}), 64'(0));

    // Directed vectors, one at a time, checking the two-cycle latency
    for (int k = 0; k < 8; k++) begin
      iv0 = 1'b1; in0 = d_w[k];
      tick();
      iv0 = 1'b0;
      chk($sformatf("dir%0d_lat1", k), 64'(ov0), 64'(0));
      tick();
      chk($sformatf("dir%0d_lat2", k), 64'(ov0), 64'(1));
      dex = d_ex[k][9:0];
      chk($sformatf("dir%0d_val", k), 64'({os0, oe0, sg0, oc0}),
          64'({d_s[k], dex, d_sig[k], d_cls[k]}));
    end
    tick();

    // Backpressure: four words offered while the sink stalls for six cycles
    or0 = 1'b0; a0 = acc0;
    for (int c = 0; c < 6; c++) begin
      iv0 = (acc0 - a0) < 4;
      if (!hold0) in0 = gen_word(8, 23);
      if (c >= 2) chk($sformatf("bp_ready%0d", c), 64'(ir0), 64'(0));
      tick();
    end
    chk("bp_accepted", 64'(acc0 - a0), 64'(2));
    or0 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      iv0 = (acc0 - a0) < 4;
      if (!hold0) in0 = gen_word(8, 23);
      chk($sformatf("bp_stream%0d", c), 64'(ov0), 64'(1));
      tick();
    end
    iv0 = 1'b0;
    chk("bp_total", 64'(acc0 - a0), 64'(4));
    chk("bp_drain", 64'(sb0.size()), 64'(0));

    // Random traffic on both lanes
    p0s = pop0; p1s = pop1; cyc = 0;
    while ((pop0 - p0s < 10000 || pop1 - p1s < 10000) && cyc < 40000) begin
      if (!hold0) begin iv0 = $urandom_range(0, 99) < 70; in0 = gen_word(8, 23); end
      if (!hold1) begin iv1 = $urandom_range(0, 99) < 70; in1 = 16'(gen_word(5, 10)); end
      or0 = $urandom_range(0, 99) < 60;
      or1 = $urandom_range(0, 99) < 60;
      tick();
      cyc++;
    end
    chk("rand_l0_words", 64'(pop0 - p0s >= 10000), 64'(1));
    chk("rand_l1_words", 64'(pop1 - p1s >= 10000), 64'(1));
    iv0 = 1'b0; iv1 = 1'b0; or0 = 1'b1; or1 = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    chk("rand_l0_nodrop", 64'(pop0), 64'(acc0));
    chk("rand_l1_nodrop", 64'(pop1), 64'(acc1));

    // Reset with both stages full
    or0 = 1'b0; or1 = 1'b0; iv0 = 1'b1; iv1 = 1'b1;
    in0 = gen_word(8, 23); in1 = 16'(gen_word(5, 10));
    for (int c = 0; c < 3; c++) tick();
    chk("full_l0_valid", 64'(ov0), 64'(1));
    chk("full_l0_ready", 64'(ir0), 64'(0));
    chk("full_l1_ready", 64'(ir1), 64'(0));
    rst = 1'b1;
    tick();
    rst = 1'b0; iv0 = 1'b0; iv1 = 1'b0; or0 = 1'b1; or1 = 1'b1;
    chk("mrst_l0_valid", 64'(ov0), 64'(0));
    chk("mrst_l0_ready", 64'(ir0), 64'(1));
    chk("mrst_l1_valid", 64'(ov1), 64'(0));
    chk("mrst_l1_ready", 64'(ir1), 64'(1));
    for (int c = 0; c < 6; c++) tick();
    chk("mrst_l0_quiet", 64'(ov0), 64'(0));
    chk("mrst_l1_quiet", 64'(ov1), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_fp_unpack_pipe
`default_nettype wire
